// File: rtl/spart_driver.sv
// Processor-side sequencer for the SPART bus interface: programs the baud divisor
// from br_cfg, then runs a polled RX->TX echo loop over iocs/iorw/ioaddr/databus.
module spart_driver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       cfg_done,
  output logic [7:0] echo_count
);

  // state    | meaning
  // CFG_LO   | write divisor low byte to addr 10
  // CFG_HI   | write divisor high byte to addr 11, configuration complete
  // RX_POLL  | read status, watch for br_cfg change or rda
  // RX_GAP   | idle POLL_GAP cycles between RX status polls
  // RX_READ  | read received byte from addr 00
  // TX_POLL  | read status, wait for tbr
  // TX_GAP   | idle POLL_GAP cycles between TX status polls
  // TX_WRITE | write held byte to addr 00
  localparam logic [2:0] CFG_LO   = 3'd0;
  localparam logic [2:0] CFG_HI   = 3'd1;
  localparam logic [2:0] RX_POLL  = 3'd2;
  localparam logic [2:0] RX_GAP   = 3'd3;
  localparam logic [2:0] RX_READ  = 3'd4;
  localparam logic [2:0] TX_POLL  = 3'd5;
  localparam logic [2:0] TX_GAP   = 3'd6;
  localparam logic [2:0] TX_WRITE = 3'd7;

  localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  logic [2:0]       state, state_nx;
  logic             running;
  logic [1:0]       br_cfg_lat;
  logic [7:0]       rx_hold;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      divisor;
  logic [7:0]       data_out;
  logic             drive_en;
  logic             rda, tbr, cfg_changed;

  assign rda         = databus[0];
  assign tbr         = databus[1];
  assign cfg_changed = (br_cfg != br_cfg_lat);

  always_comb begin
    divisor = DIV_4800;
    case (br_cfg_lat)
      2'b00:   divisor = DIV_4800;
      2'b01:   divisor = DIV_9600;
      2'b10:   divisor = DIV_19200;
      default: divisor = DIV_38400;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      CFG_LO:   state_nx = CFG_HI;
      CFG_HI:   state_nx = RX_POLL;
      RX_POLL: begin
        if (cfg_changed)        state_nx = CFG_LO;
        else if (rda)           state_nx = RX_READ;
        else if (POLL_GAP == 0) state_nx = RX_POLL;
        else                    state_nx = RX_GAP;
      end
      RX_GAP:   if (gap_cnt == '0) state_nx = RX_POLL;
      RX_READ:  state_nx = TX_POLL;
      TX_POLL: begin
        if (tbr)                state_nx = TX_WRITE;
        else if (POLL_GAP == 0) state_nx = TX_POLL;
        else                    state_nx = TX_GAP;
      end
      TX_GAP:   if (gap_cnt == '0) state_nx = TX_POLL;
      TX_WRITE: state_nx = RX_POLL;
      default:  state_nx = CFG_LO;
    endcase
  end

  // The first clock after reset release only latches br_cfg; bus activity starts next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CFG_LO;
      running    <= 1'b0;
      br_cfg_lat <= 2'b00;
      rx_hold    <= 8'h00;
      gap_cnt    <= '0;
      cfg_done   <= 1'b0;
      echo_count <= 8'h00;
    end else if (!running) begin
      running    <= 1'b1;
      br_cfg_lat <= br_cfg;
    end else begin
      state <= state_nx;
      if (state == RX_POLL || state == TX_POLL)
        gap_cnt <= GAP_LOAD;
      else if ((state == RX_GAP || state == TX_GAP) && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      case (state)
        CFG_HI:   cfg_done <= 1'b1;
        RX_POLL: begin
          if (cfg_changed) begin
            br_cfg_lat <= br_cfg;
            cfg_done   <= 1'b0;
          end
        end
        RX_READ:  rx_hold    <= databus;
        TX_WRITE: echo_count <= echo_count + 8'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = 2'b00;
    data_out = rx_hold;
    if (running) begin
      case (state)
        CFG_LO:   begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10; data_out = divisor[7:0];  end
        CFG_HI:   begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; data_out = divisor[15:8]; end
        RX_POLL,
        TX_POLL:  begin iocs = 1'b1; ioaddr = 2'b01; end
        RX_READ:  begin iocs = 1'b1; ioaddr = 2'b00; end
        TX_WRITE: begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; end
        default:  ;
      endcase
    end
  end

  assign drive_en = iocs && !iorw;
  assign databus  = drive_en ? data_out : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a small bus-interface model answers status and RX reads,
// and each bus access is checked against hand-computed values.
module tb_spart_driver;

  logic       clk;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] echo_count;
  wire  [7:0] databus;

  logic       rda, tbr;
  logic [7:0] rx_byte;
  int         checks, errors, tx_cnt;
  logic [7:0] last_tx;
  logic [7:0] exp_echo;

  spart_driver #(.CLK_FREQ(50_000_000), .POLL_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .databus(databus), .cfg_done(cfg_done), .echo_count(echo_count)
  );

  // Bus-interface model; status bits [7:2] carry junk the driver must ignore.
  assign databus = (iocs && iorw) ? ((ioaddr == 2'b01) ? {6'b110100, tbr, rda} :
                                     (ioaddr == 2'b00) ? rx_byte : 8'h00) : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] rx;
    logic [7:0] exp_lo;
    logic [7:0] exp_hi;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (iocs && iorw && ioaddr == 2'b00) rda = 1'b0;
    if (iocs && !iorw && ioaddr == 2'b00) begin
      tx_cnt++;
      last_tx = databus;
    end
  endtask

  task automatic wait_for(input logic [1:0] addr, input logic rw, input int max, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(iocs && iorw == rw && ioaddr == addr) && n < max);
    checks++;
    if (!(iocs && iorw == rw && ioaddr == addr)) begin
      errors++;
      $display("FAIL %s: access addr %b rw %b not seen within %0d cycles", name, addr, rw, max);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int polls, busy, tx0;
    vecs[0] = '{cfg: 2'b00, rx: 8'hC3, exp_lo: 8'h8A, exp_hi: 8'h02};
    vecs[1] = '{cfg: 2'b10, rx: 8'h3C, exp_lo: 8'hA1, exp_hi: 8'h00};
    vecs[2] = '{cfg: 2'b01, rx: 8'h00, exp_lo: 8'h44, exp_hi: 8'h01};
    vecs[3] = '{cfg: 2'b11, rx: 8'hFF, exp_lo: 8'h50, exp_hi: 8'h00};
    checks = 0; errors = 0; tx_cnt = 0; last_tx = 8'h00; exp_echo = 8'h00;
    rst_n = 1'b0; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;

    // 1: reset values, initial divisor programming, poll cadence
    step(); step();
    chk("reset_bus", {iocs, iorw, ioaddr}, 4'b0100);
    chk("reset_cfg_done", cfg_done, 1'b0);
    chk("reset_echo", echo_count, 8'h00);
    rst_n = 1'b1;
    step();
    chk("cfg_lo_bus", {iocs, iorw, ioaddr}, 4'b1010);
    chk("cfg_lo_data", databus, 8'h8A);
    chk("cfg_lo_done", cfg_done, 1'b0);
    step();
    chk("cfg_hi_bus", {iocs, iorw, ioaddr}, 4'b1011);
    chk("cfg_hi_data", databus, 8'h02);
    step();
    chk("first_poll_bus", {iocs, iorw, ioaddr}, 4'b1101);
    chk("first_poll_done", cfg_done, 1'b1);
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (iocs) busy++;
    end
    chk("gap_idle", busy, 0);
    step();
    chk("second_poll_bus", {iocs, iorw, ioaddr}, 4'b1101);

    // 2: echo 0x41 with tbr already set, 3-cycle latency
    rda = 1'b1; tbr = 1'b1; rx_byte = 8'h41;
    step();
    chk("rx_read_bus", {iocs, iorw, ioaddr}, 4'b1100);
    step();
    chk("tx_poll_bus", {iocs, iorw, ioaddr}, 4'b1101);
    step();
    chk("tx_write_bus", {iocs, iorw, ioaddr}, 4'b1000);
    chk("tx_write_data", databus, 8'h41);
    step();
    exp_echo = 8'd1;
    chk("echo_count_1", echo_count, exp_echo);

    // 3: tbr held low for 50 cycles after the RX read
    wait_for(2'b01, 1'b1, 8, "poll_before_t3");
    rda = 1'b1; tbr = 1'b0; rx_byte = 8'h41;
    step();
    chk("t3_rx_read", {iocs, iorw, ioaddr}, 4'b1100);
    tx0 = tx_cnt; polls = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (iocs && iorw && ioaddr == 2'b01) polls++;
    end
    chk("t3_no_write", tx_cnt - tx0, 0);
    chk("t3_poll_count", polls, 10);
    tbr = 1'b1;
    wait_for(2'b00, 1'b0, 8, "t3_write");
    chk("t3_write_data", databus, 8'h41);
    step();
    exp_echo++;
    chk("echo_count_2", echo_count, exp_echo);

    // 4: idle reconfiguration 00 -> 11
    wait_for(2'b01, 1'b1, 8, "poll_before_t4");
    chk("t4_done_before", cfg_done, 1'b1);
    br_cfg = 2'b11;
    step();
    chk("t4_lo_bus", {iocs, iorw, ioaddr}, 4'b1010);
    chk("t4_lo_data", databus, 8'h50);
    chk("t4_lo_done", cfg_done, 1'b0);
    step();
    chk("t4_hi_bus", {iocs, iorw, ioaddr}, 4'b1011);
    chk("t4_hi_data", databus, 8'h00);
    chk("t4_hi_done", cfg_done, 1'b0);
    step();
    chk("t4_poll_done", {iocs, iorw, ioaddr, cfg_done}, 5'b11011);

    // table: reconfigure then echo one byte for each baud select
    for (int v = 0; v < 4; v++) begin
      wait_for(2'b01, 1'b1, 8, "tbl_poll");
      br_cfg = vecs[v].cfg;
      step();
      chk("tbl_lo_bus", {iocs, iorw, ioaddr}, 4'b1010);
      chk("tbl_lo_data", databus, vecs[v].exp_lo);
      step();
      chk("tbl_hi_data", databus, vecs[v].exp_hi);
      step();
      chk("tbl_poll_done", {iocs, iorw, ioaddr, cfg_done}, 5'b11011);
      rda = 1'b1; tbr = 1'b1; rx_byte = vecs[v].rx;
      step(); step(); step();
      chk("tbl_write_bus", {iocs, iorw, ioaddr}, 4'b1000);
      chk("tbl_write_data", databus, vecs[v].rx);
      step();
      exp_echo++;
      chk("tbl_echo_count", echo_count, exp_echo);
    end

    // 5: br_cfg change while waiting in TX_GAP with 0x5A pending
    wait_for(2'b01, 1'b1, 8, "poll_before_t5");
    rda = 1'b1; tbr = 1'b0; rx_byte = 8'h5A;
    step(); step(); step();
    chk("t5_in_gap", iocs, 1'b0);
    br_cfg = 2'b01;
    step(); step();
    tbr = 1'b1;
    wait_for(2'b00, 1'b0, 8, "t5_write");
    chk("t5_write_data", databus, 8'h5A);
    step();
    exp_echo++;
    chk("t5_echo_count", echo_count, exp_echo);
    chk("t5_poll_bus", {iocs, iorw, ioaddr}, 4'b1101);
    step();
    chk("t5_lo", {iocs, iorw, ioaddr, databus}, {4'b1010, 8'h44});
    step();
    chk("t5_hi", {iocs, iorw, ioaddr, databus}, {4'b1011, 8'h01});

    // 6: reset during TX_GAP discards the pending byte
    wait_for(2'b01, 1'b1, 8, "poll_before_t6");
    rda = 1'b1; tbr = 1'b0; rx_byte = 8'h77;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_bus", {iocs, iorw, ioaddr}, 4'b0100);
    chk("t6_rst_done", cfg_done, 1'b0);
    chk("t6_rst_echo", echo_count, 8'h00);
    step();
    tx0 = tx_cnt; tbr = 1'b1;
    rst_n = 1'b1;
    step();
    chk("t6_lo", {iocs, iorw, ioaddr, databus}, {4'b1010, 8'h44});
    step();
    chk("t6_hi", {iocs, iorw, ioaddr, databus}, {4'b1011, 8'h01});
    for (int i = 0; i < 30; i++) step();
    chk("t6_no_echo", tx_cnt - tx0, 0);
    chk("t6_echo_count", echo_count, 8'h00);

    // 256 echoes wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      wait_for(2'b01, 1'b1, 8, "wrap_poll");
      rda = 1'b1; tbr = 1'b1; rx_byte = 8'(i);
      wait_for(2'b00, 1'b0, 6, "wrap_write");
      chk("wrap_data", databus, 16'(i[7:0]));
    end
    step();
    chk("wrap_echo_count", echo_count, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
